// File: rtl/morse_disp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | morse_disp_pkg                                                         |
// | Shared character codes and 7-segment glyph table for the Morse display |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package morse_disp_pkg;

    localparam logic [5:0] CODE_SPACE  = 6'd63;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam int         GLYPH_COUNT = 36;

    // Active-high patterns, bit order g..a; codes 0-9 then A-Z.
    localparam logic [6:0] GLYPH_ROM [GLYPH_COUNT] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h30, 7'h1E,
        7'h75, 7'h38, 7'h37, 7'h54, 7'h3F, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78,
        7'h3E, 7'h1C, 7'h2A, 7'h76, 7'h6E, 7'h5B
    };

    function automatic logic [6:0] to_active_low(input logic [6:0] seg_on);
        return ~seg_on;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg_glyph_decode                                                       |
// | Character code to active-low 7-segment pattern                         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module seg_glyph_decode
    import morse_disp_pkg::*;
#(
    parameter int CODE_W = 6
) (
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg
);

    always_comb begin
        if (code == CODE_W'(CODE_SPACE)) begin
            seg = GLYPH_BLANK;
        end else if (code < CODE_W'(GLYPH_COUNT)) begin
            seg = to_active_low(GLYPH_ROM[code]);
        end else begin
            seg = GLYPH_DASH;
        end
    end

endmodule
`default_nettype wire

// File: rtl/morse_scroll_display.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | morse_scroll_display                                                   |
// | Character history buffer driving a static or scrolling 7-seg bank      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module morse_scroll_display
    import morse_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DEPTH      = 16,
    parameter int CODE_W     = 6,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       char_valid,
    input  logic [CODE_W-1:0]          char_code,
    input  logic                       clear,
    input  logic                       mode,
    output logic [NUM_DIGITS-1:0][6:0] hex,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_OW = $clog2(DEPTH + NUM_DIGITS + 1);
    localparam int c_SW = c_OW + 1;
    localparam int c_DW = $clog2(SCROLL_DIV);
    localparam logic [c_PW-1:0] c_PMASK = c_PW'(DEPTH - 1);

    logic [CODE_W-1:0]          r_mem [DEPTH];
    logic [c_PW-1:0]            r_wptr;
    logic [c_CW-1:0]            r_count;
    logic [c_OW-1:0]            r_offset;
    logic [c_DW-1:0]            r_presc;
    logic                       r_mode_q;
    logic [NUM_DIGITS-1:0][6:0] r_hex;

    logic [c_SW-1:0]            w_len;
    logic [c_OW-1:0]            w_offset_inc;
    logic [NUM_DIGITS-1:0][6:0] w_glyph;

    assign w_len        = c_SW'(r_count) + c_SW'(NUM_DIGITS);
    assign w_offset_inc = r_offset + c_OW'(1);
    assign hex          = r_hex;
    assign count        = r_count;

    // History storage kept reset-free so it maps onto RAM; count gates validity.
    always_ff @(posedge clk) begin
        if (!reset && char_valid && !clear) begin
            r_mem[r_wptr] <= char_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_count  <= '0;
            r_offset <= '0;
            r_presc  <= '0;
            r_mode_q <= 1'b0;
            r_hex    <= {NUM_DIGITS{GLYPH_BLANK}};
        end else begin
            r_mode_q <= mode;
            r_hex    <= w_glyph;
            if (clear) begin
                r_wptr   <= '0;
                r_count  <= '0;
                r_offset <= '0;
                r_presc  <= '0;
            end else begin
                if (char_valid) begin
                    r_wptr <= (r_wptr + c_PW'(1)) & c_PMASK;
                    if (r_count != c_CW'(DEPTH)) begin
                        r_count <= r_count + c_CW'(1);
                    end
                end
                // Scroll position is parked at 0 outside an active, non-empty scroll.
                if (!mode || (mode != r_mode_q) || (r_count == '0)) begin
                    r_offset <= '0;
                    r_presc  <= '0;
                end else if (r_presc == c_DW'(SCROLL_DIV - 1)) begin
                    r_presc  <= '0;
                    r_offset <= (c_SW'(w_offset_inc) == w_len) ? '0 : w_offset_inc;
                end else begin
                    r_presc <= r_presc + c_DW'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [c_SW-1:0]   w_sum;
        logic [c_SW-1:0]   w_pos;
        logic [c_PW-1:0]   w_sidx;
        logic [c_PW-1:0]   w_ridx;
        logic [CODE_W-1:0] w_code;

        // offset < L and the digit term < L, so one conditional subtract is a full mod L.
        always_comb begin
            w_sum  = c_SW'(r_offset) + c_SW'(NUM_DIGITS - 1 - gi);
            w_pos  = (w_sum >= w_len) ? (w_sum - w_len) : w_sum;
            w_sidx = (r_wptr - c_PW'(gi + 1)) & c_PMASK;
            w_ridx = (r_wptr - c_PW'(r_count) + c_PW'(w_pos)) & c_PMASK;
            w_code = CODE_W'(CODE_SPACE);
            if (mode) begin
                if (w_pos < c_SW'(r_count)) begin
                    w_code = r_mem[w_ridx];
                end
            end else if (c_CW'(gi) < r_count) begin
                w_code = r_mem[w_sidx];
            end
        end

        seg_glyph_decode #(
            .CODE_W (CODE_W)
        ) u_glyph (
            .code (w_code),
            .seg  (w_glyph[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_scroll_display.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_morse_scroll_display                                                |
// | Scoreboard bench: expected frames queued by cycle, checked by monitor  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_morse_scroll_display;

    localparam logic [6:0] BL  = 7'h7F;
    localparam logic [6:0] DSH = 7'h3F;
    localparam logic [6:0] GA  = 7'h08;
    localparam logic [6:0] GB  = 7'h03;
    localparam logic [6:0] GS  = 7'h12;
    localparam logic [6:0] GO  = 7'h40;
    localparam logic [6:0] GDIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             char_valid = 1'b0;
    logic [5:0]       char_code = '0;
    logic             clear = 1'b0;
    logic             mode = 1'b0;
    logic [5:0][6:0]  hex;
    logic [3:0]       count;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int              cyc;
        logic [5:0][6:0] hex;
        logic [3:0]      cnt;
        string           name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    morse_scroll_display #(
        .NUM_DIGITS (6),
        .DEPTH      (8),
        .CODE_W     (6),
        .SCROLL_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_code  (char_code),
        .clear      (clear),
        .mode       (mode),
        .hex        (hex),
        .count      (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation whose cycle has come.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            n_checks++;
            if (hex !== mon_e.hex) begin
                n_fail++;
                $display("FAIL %s hex: got %h expected %h (cycle %0d)", mon_e.name, hex, mon_e.hex, cyc);
            end
            n_checks++;
            if (count !== mon_e.cnt) begin
                n_fail++;
                $display("FAIL %s count: got %0d expected %0d (cycle %0d)", mon_e.name, count, mon_e.cnt, cyc);
            end
        end
    end

    function automatic logic [41:0] fr(input logic [6:0] h5, h4, h3, h2, h1, h0);
        return {h5, h4, h3, h2, h1, h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input logic [41:0] h, input logic [3:0] c, input string nm);
        exp_t ent;
        ent.cyc  = cyc + d;
        ent.hex  = h;
        ent.cnt  = c;
        ent.name = nm;
        q.push_back(ent);
    endtask

    task automatic push(input logic [5:0] code);
        char_valid = 1'b1;
        char_code  = code;
        step();
        char_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    int base;

    initial begin
        // Reset state
        step();
        expect_at(0, fr(BL, BL, BL, BL, BL, BL), 4'd0, "in_reset");
        step();
        reset = 1'b0;
        repeat (10) step();
        expect_at(0, fr(BL, BL, BL, BL, BL, BL), 4'd0, "idle");

        // Static S O S, including the one-cycle-early boundary
        push(6'd28);
        push(6'd24);
        push(6'd28);
        expect_at(0, fr(BL, BL, BL, BL, GS, GO), 4'd3, "sos_latency");
        expect_at(1, fr(BL, BL, BL, GS, GO, GS), 4'd3, "sos_static");
        step();
        step();

        // Overflow: 0..9 into an 8-deep history
        do_clear();
        for (int i = 0; i < 10; i++) push(6'(i));
        expect_at(1, fr(GDIG[4], GDIG[5], GDIG[6], GDIG[7], GDIG[8], GDIG[9]), 4'd8, "overflow");
        step();
        step();

        // Scroll marquee of "AB"
        do_clear();
        push(6'd10);
        push(6'd11);
        expect_at(1, fr(BL, BL, BL, BL, GA, GB), 4'd2, "ab_static");
        step();
        step();
        mode = 1'b1;
        step();
        expect_at(0,  fr(GA, GB, BL, BL, BL, BL), 4'd2, "scroll_off0");
        expect_at(4,  fr(GA, GB, BL, BL, BL, BL), 4'd2, "scroll_hold");
        expect_at(5,  fr(GB, BL, BL, BL, BL, BL), 4'd2, "scroll_off1");
        expect_at(9,  fr(BL, BL, BL, BL, BL, BL), 4'd2, "scroll_off2");
        expect_at(13, fr(BL, BL, BL, BL, BL, GA), 4'd2, "scroll_off3");
        expect_at(29, fr(BL, GA, GB, BL, BL, BL), 4'd2, "scroll_off7");
        expect_at(33, fr(GA, GB, BL, BL, BL, BL), 4'd2, "scroll_wrap");
        repeat (34) step();

        // Clear wins over a simultaneous push
        char_valid = 1'b1;
        char_code  = 6'd12;
        clear      = 1'b1;
        step();
        char_valid = 1'b0;
        clear      = 1'b0;
        expect_at(1, fr(BL, BL, BL, BL, BL, BL), 4'd0, "clear_push");
        step();
        step();
        push(6'd10);
        expect_at(1, fr(GA, BL, BL, BL, BL, BL), 4'd1, "after_clear_scroll");
        step();
        step();

        // Invalid code and space
        mode = 1'b0;
        do_clear();
        push(6'd40);
        push(6'd63);
        expect_at(1, fr(BL, BL, BL, BL, DSH, BL), 4'd2, "dash_space");
        step();
        step();

        // Reset in the middle of a scroll at offset 3
        do_clear();
        push(6'd10);
        push(6'd11);
        step();
        mode = 1'b1;
        step();
        expect_at(13, fr(BL, BL, BL, BL, BL, GA), 4'd2, "pre_reset_off3");
        repeat (13) step();
        reset = 1'b1;
        step();
        expect_at(0, fr(BL, BL, BL, BL, BL, BL), 4'd0, "reset_scroll");
        reset = 1'b0;
        step();
        expect_at(0, fr(BL, BL, BL, BL, BL, BL), 4'd0, "post_reset");
        step();
        push(6'd10);
        expect_at(1, fr(GA, BL, BL, BL, BL, BL), 4'd1, "post_reset_push");

        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_scroll_display.md
Name: morse_scroll_display

Overview:
- Sequential successor to the single-character 7-segment decoder. Accepts decoded Morse character codes from the decoder FSM and keeps a history buffer of the most recent characters.
- Drives a parametrised bank of active-low 7-segment digits in one of two modes:
  - static: the newest characters, right-aligned;
  - scroll: a marquee of the whole history, advanced by a prescaled tick.
- Sits between the Morse decoder and the board HEX pins.

Parameters:
- NUM_DIGITS, 6, number of 7-segment digits driven (1..8).
- DEPTH, 16, history buffer entries; power of two, DEPTH >= NUM_DIGITS.
- CODE_W, 6, character code width.
- SCROLL_DIV, 25000000, clk cycles per scroll step (>= 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- char_valid  in  1  one-cycle strobe: char_code holds a new character.
- char_code  in  CODE_W  0-9 = digits 0-9; 10-35 = A-Z; 63 = space; other codes are invalid.
- clear  in  1  synchronous history flush.
- mode  in  1  0 = static, 1 = scroll.
- hex  out  NUM_DIGITS x 7  active-low segment patterns. Element 0 is the rightmost digit. Bit order is g..a (bit 6 = g).
- count  out  $clog2(DEPTH+1)  number of valid history entries.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset:
  - history emptied; count = 0;
  - scroll offset = 0; prescaler = 0;
  - every hex element = 7'h7F (all segments off).
- Push: on char_valid, char_code is written at the write pointer, the pointer increments modulo DEPTH, and count saturates at DEPTH.
  - When full, the oldest entry is overwritten. The block never back-pressures.
  - Invalid codes (36-62) are stored as-is and render as a dash (segment g only).
- Clear:
  - count := 0; write pointer := 0; offset := 0; prescaler := 0.
  - clear has priority over char_valid in the same cycle; that character is dropped.
- Static mode (mode = 0):
  - hex[i] shows the character of age i (age 0 = newest) when i < count, otherwise blank.
  - Example: after pushing 'S', 'O', 'S', hex[2..0] = S, O, S and the higher digits are blank.
- Scroll mode (mode = 1):
  - Virtual string V = history oldest→newest, followed by NUM_DIGITS blanks; L = count + NUM_DIGITS.
  - Leftmost digit hex[NUM_DIGITS-1] shows V[offset]; hex[i] shows V[(offset + NUM_DIGITS-1-i) mod L].
  - The prescaler counts 0..SCROLL_DIV-1. On wrap, offset := (offset+1) mod L.
  - A push does not change offset. If the push grows L, the new modulus applies from the next step.
  - If count is 0, every digit is blank and offset stays 0.
  - If a push overwrites the oldest entry, indices shift by one. No correction is applied.
  - If offset >= L after a clear, it is forced to 0. Offset must always be < L.
- Mode change: any change of mode resets offset and prescaler to 0 on the following edge.
- Output latency:
  - hex is registered: one cycle from any state change to the visible output.
  - A push on cycle N is visible on hex at cycle N+2: the buffer write takes one cycle, then the output register takes one.
- Glyphs: one glyph per digit from the shared glyph table. Blank = 7'h7F. Dash = 7'h3F (active-low, g lit).

Decomposition:
- Package morse_disp_pkg holds:
  - CODE_SPACE = 6'd63;
  - GLYPH_BLANK and GLYPH_DASH constants;
  - the 36-entry active-high glyph ROM (0-9, A-Z);
  - the function to_active_low().
- Sub-module seg_glyph_decode: combinational code → active-low 7-bit pattern. Instantiated once per digit in a generate loop.
- Top level holds the buffer RAM, pointers, count, prescaler, offset and output registers.

Test Plan (NUM_DIGITS = 6, DEPTH = 8, SCROLL_DIV = 4):
- Reset, then idle 10 cycles → all hex = 7'h7F, count = 0.
- Static push of codes 28 'S', 24 'O', 28 'S' → two cycles after the last push: hex[0] = S, hex[1] = O, hex[2] = S (0x12 / 0x40 / 0x12 active-low, i.e. 0x12 for 'S' and 0x40 for 'O' in the team's code-to-segment set), hex[5:3] = 7'h7F, count = 3.
- Overflow: push 0..9 (10 chars) → count = 8. In static mode, hex[0] = '9' and hex[5] = '4'.
- Scroll with history "AB" (count = 2, L = 8):
  - after mode := 1, hex[5] = 'A' and hex[4] = 'B';
  - after 4 cycles, hex[5] = 'B';
  - after 32 cycles, the display is back to the initial frame.
- Push with clear asserted in the same cycle → count = 0, all digits blank, offset = 0, character not stored.
- Push invalid code 40 and code 63 → the digit for code 40 = 7'h3F (dash), the digit for code 63 = 7'h7F (blank).
- Assert reset during scroll at offset 3 → the next cycle has offset 0 and count 0, and all hex = 7'h7F one cycle later.
